// File: rtl/vagas_pkg.sv
// Shared definitions for the two-block parking lot: controller states,
// lot geometry and block encodings.
package vagas_pkg;

   typedef enum logic [1:0] {
      LIVRE    = 2'd0,
      ABERTA   = 2'd1,
      FECHANDO = 2'd2
   } estado_t;

   localparam int   NUM_VAGAS = 4;
   localparam logic BLOCO_E   = 1'b0;
   localparam logic BLOCO_D   = 1'b1;

   // One-hot mask of a spot number inside its block.
   function automatic logic [NUM_VAGAS-1:0] mascara_vaga(input logic [1:0] vaga);
      mascara_vaga = {{(NUM_VAGAS-1){1'b0}}, 1'b1} << vaga;
   endfunction

endpackage

// File: rtl/temporizador_cancela.sv
// Gate-open timer: clear/enable counter with a terminal-count flag that is
// asserted while the count equals TERMINAL-1.
module temporizador_cancela #(
   parameter int W        = 10,
   parameter int TERMINAL = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic limpa,
   input  logic habilita,
   output logic fim
);

   localparam logic [W-1:0] FIM_C = W'(TERMINAL - 1);

   logic [W-1:0] cont_r;

   // Counter register: clear has priority over enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cont_r <= {W{1'b0}};
      end else if (limpa) begin
         cont_r <= {W{1'b0}};
      end else if (habilita) begin
         cont_r <= cont_r + {{(W-1){1'b0}}, 1'b1};
      end else begin
         cont_r <= cont_r;
      end
   end

   assign fim = (cont_r == FIM_C);

endmodule

// File: rtl/gerenciador_vagas.sv
// Entry/exit controller: reserves the spot chosen by the selector, opens the
// gate, waits for the car (or times out), and frees spots on exit.
module gerenciador_vagas
   import vagas_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = 1000,
   parameter int CONT_W         = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 CHEGADA,
   input  logic                 SENSOR,
   input  logic                 SAIDA,
   input  logic                 SAIDA_B,
   input  logic [1:0]           SAIDA_V,
   input  logic [1:0]           V_SEL,
   input  logic                 L_SEL,
   input  logic                 B_SEL,
   output logic [NUM_VAGAS-1:0] VE,
   output logic [NUM_VAGAS-1:0] VD,
   output logic                 CANCELA,
   output logic [1:0]           V_ATR,
   output logic                 B_ATR,
   output logic                 LOTADO,
   output logic                 EXPIROU
);

   estado_t                estado_r, estado_prox_s;
   logic                   chegada_d_r;
   logic [NUM_VAGAS-1:0]   ve_r, vd_r, ve_prox_s, vd_prox_s;
   logic                   cancela_r, cancela_prox_s;
   logic [1:0]             v_atr_r, v_atr_prox_s;
   logic                   b_atr_r, b_atr_prox_s;
   logic                   lotado_r, lotado_prox_s;
   logic                   expirou_r, expirou_prox_s;
   logic                   fim_s, pedido_s, reserva_s, lotar_s, expira_s;
   logic                   saida_ok_s, liberou_s;
   logic [NUM_VAGAS-1:0]   m_saida_s, m_atr_s, m_sel_s;
   logic [NUM_VAGAS-1:0]   clr_e_s, clr_d_s, set_e_s, set_d_s;

   temporizador_cancela #(
      .W        (CONT_W),
      .TERMINAL (TIMEOUT_CICLOS)
   ) u_temporizador (
      .clk      (clk),
      .rst_n    (rst_n),
      .limpa    (estado_r != ABERTA),
      .habilita (estado_r == ABERTA),
      .fim      (fim_s)
   );

   assign pedido_s  = CHEGADA & ~chegada_d_r;
   assign reserva_s = (estado_r == LIVRE) & pedido_s & L_SEL;
   assign lotar_s   = (estado_r == LIVRE) & pedido_s & ~L_SEL;
   // SENSOR wins over a simultaneous timeout.
   assign expira_s  = (estado_r == ABERTA) & ~SENSOR & fim_s;
   // An exit aimed at the spot still being reserved is dropped.
   assign saida_ok_s = SAIDA & ~((estado_r == ABERTA) & (SAIDA_B == b_atr_r) & (SAIDA_V == v_atr_r));

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado_r    <= LIVRE;
         chegada_d_r <= 1'b0;
         ve_r        <= {NUM_VAGAS{1'b0}};
         vd_r        <= {NUM_VAGAS{1'b0}};
         cancela_r   <= 1'b0;
         v_atr_r     <= 2'd0;
         b_atr_r     <= 1'b0;
         lotado_r    <= 1'b0;
         expirou_r   <= 1'b0;
      end else begin
         estado_r    <= estado_prox_s;
         chegada_d_r <= CHEGADA;
         ve_r        <= ve_prox_s;
         vd_r        <= vd_prox_s;
         cancela_r   <= cancela_prox_s;
         v_atr_r     <= v_atr_prox_s;
         b_atr_r     <= b_atr_prox_s;
         lotado_r    <= lotado_prox_s;
         expirou_r   <= expirou_prox_s;
      end
   end

   // Next-state logic.
   always_comb begin
      estado_prox_s = estado_r;
      case (estado_r)
         LIVRE:    estado_prox_s = reserva_s ? ABERTA : LIVRE;
         ABERTA:   estado_prox_s = (SENSOR | fim_s) ? FECHANDO : ABERTA;
         FECHANDO: estado_prox_s = LIVRE;
         default:  estado_prox_s = LIVRE;
      endcase
   end

   // Next output values: occupancy update, gate, assignment and flags.
   always_comb begin
      m_saida_s = saida_ok_s ? mascara_vaga(SAIDA_V) : {NUM_VAGAS{1'b0}};
      m_atr_s   = expira_s   ? mascara_vaga(v_atr_r) : {NUM_VAGAS{1'b0}};
      m_sel_s   = reserva_s  ? mascara_vaga(V_SEL)   : {NUM_VAGAS{1'b0}};
      clr_e_s   = ((SAIDA_B == BLOCO_E) ? m_saida_s : {NUM_VAGAS{1'b0}})
                | ((b_atr_r == BLOCO_E) ? m_atr_s   : {NUM_VAGAS{1'b0}});
      clr_d_s   = ((SAIDA_B == BLOCO_D) ? m_saida_s : {NUM_VAGAS{1'b0}})
                | ((b_atr_r == BLOCO_D) ? m_atr_s   : {NUM_VAGAS{1'b0}});
      set_e_s   = (B_SEL == BLOCO_E) ? m_sel_s : {NUM_VAGAS{1'b0}};
      set_d_s   = (B_SEL == BLOCO_D) ? m_sel_s : {NUM_VAGAS{1'b0}};
      ve_prox_s = (ve_r & ~clr_e_s) | set_e_s;
      vd_prox_s = (vd_r & ~clr_d_s) | set_d_s;
      liberou_s = (|(ve_r & ~ve_prox_s)) | (|(vd_r & ~vd_prox_s));

      if (liberou_s) begin
         lotado_prox_s = 1'b0;
      end else if (lotar_s) begin
         lotado_prox_s = 1'b1;
      end else begin
         lotado_prox_s = lotado_r;
      end

      if (reserva_s) begin
         v_atr_prox_s = V_SEL;
         b_atr_prox_s = B_SEL;
      end else begin
         v_atr_prox_s = v_atr_r;
         b_atr_prox_s = b_atr_r;
      end

      cancela_prox_s = 1'b0;
      case (estado_r)
         LIVRE:    cancela_prox_s = reserva_s;
         ABERTA:   cancela_prox_s = ~(SENSOR | fim_s);
         FECHANDO: cancela_prox_s = 1'b0;
         default:  cancela_prox_s = 1'b0;
      endcase

      expirou_prox_s = expira_s;
   end

   assign VE      = ve_r;
   assign VD      = vd_r;
   assign CANCELA = cancela_r;
   assign V_ATR   = v_atr_r;
   assign B_ATR   = b_atr_r;
   assign LOTADO  = lotado_r;
   assign EXPIROU = expirou_r;

endmodule

// File: tb/tb_gerenciador_vagas.sv
// Directed bench for gerenciador_vagas: expected outputs are queued when a
// step is driven and compared one edge later.
module tb_gerenciador_vagas;

   typedef struct packed {
      logic [3:0] ve;
      logic [3:0] vd;
      logic       cancela;
      logic [1:0] v_atr;
      logic       b_atr;
      logic       lotado;
      logic       expirou;
   } saidas_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       CHEGADA = 1'b0, SENSOR = 1'b0, SAIDA = 1'b0, SAIDA_B = 1'b0;
   logic [1:0] SAIDA_V = 2'd0, V_SEL = 2'd0;
   logic       L_SEL = 1'b0, B_SEL = 1'b0;
   logic [3:0] VE, VD;
   logic       CANCELA, B_ATR, LOTADO, EXPIROU;
   logic [1:0] V_ATR;

   logic [3:0] e_ve = 4'h0, e_vd = 4'h0;
   logic       e_can = 1'b0, e_b = 1'b0, e_lot = 1'b0, e_exp = 1'b0;
   logic [1:0] e_v = 2'd0;

   saidas_t fila[$];
   int      total = 0;
   int      passou = 0;

   gerenciador_vagas #(
      .TIMEOUT_CICLOS (8),
      .CONT_W         (10)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .CHEGADA (CHEGADA),
      .SENSOR  (SENSOR),
      .SAIDA   (SAIDA),
      .SAIDA_B (SAIDA_B),
      .SAIDA_V (SAIDA_V),
      .V_SEL   (V_SEL),
      .L_SEL   (L_SEL),
      .B_SEL   (B_SEL),
      .VE      (VE),
      .VD      (VD),
      .CANCELA (CANCELA),
      .V_ATR   (V_ATR),
      .B_ATR   (B_ATR),
      .LOTADO  (LOTADO),
      .EXPIROU (EXPIROU)
   );

   always #5 clk = ~clk;

   task automatic zera_esperado();
      e_ve = 4'h0; e_vd = 4'h0; e_can = 1'b0; e_v = 2'd0;
      e_b = 1'b0; e_lot = 1'b0; e_exp = 1'b0;
   endtask

   // Queue the current expectation, advance one edge, then compare.
   task automatic passo(input string tag);
      saidas_t esp, obs;
      fila.push_back({e_ve, e_vd, e_can, e_v, e_b, e_lot, e_exp});
      @(posedge clk);
      #1;
      obs = {VE, VD, CANCELA, V_ATR, B_ATR, LOTADO, EXPIROU};
      esp = fila.pop_front();
      total++;
      assert (obs === esp) passou++;
      else begin
         $display("FAIL %s: got ve=%h vd=%h can=%b v=%0d b=%b lot=%b exp=%b, want ve=%h vd=%h can=%b v=%0d b=%b lot=%b exp=%b",
                  tag, obs.ve, obs.vd, obs.cancela, obs.v_atr, obs.b_atr, obs.lotado, obs.expirou,
                  esp.ve, esp.vd, esp.cancela, esp.v_atr, esp.b_atr, esp.lotado, esp.expirou);
         $error("check %s", tag);
      end
   endtask

   initial begin
      // Reset
      zera_esperado();
      passo("reset0");
      passo("reset1");
      rst_n = 1'b1;

      // Reserve E3, gate opens next edge
      CHEGADA = 1'b1; V_SEL = 2'd3; B_SEL = 1'b0; L_SEL = 1'b1;
      e_ve = 4'b1000; e_can = 1'b1; e_v = 2'd3; e_b = 1'b0;
      passo("abre_e3");
      CHEGADA = 1'b0;
      for (int i = 0; i < 4; i++) passo("aberta_e3");
      SENSOR = 1'b1;
      e_can = 1'b0;
      passo("sensor_fecha");
      SENSOR = 1'b0;
      passo("fechando");

      // Reserve D1, exit on D1 ignored, exit on E3 honoured, then timeout
      CHEGADA = 1'b1; V_SEL = 2'd1; B_SEL = 1'b1; L_SEL = 1'b1;
      e_vd = 4'b0010; e_can = 1'b1; e_v = 2'd1; e_b = 1'b1;
      passo("abre_d1");
      CHEGADA = 1'b0;
      SAIDA = 1'b1; SAIDA_B = 1'b1; SAIDA_V = 2'd1;
      passo("saida_reservada_ignorada");
      SAIDA_B = 1'b0; SAIDA_V = 2'd3;
      e_ve = 4'b0000;
      passo("saida_e3");
      SAIDA = 1'b0;
      for (int i = 0; i < 5; i++) passo("espera_timeout");
      e_vd = 4'b0000; e_can = 1'b0; e_exp = 1'b1;
      passo("expirou");
      e_exp = 1'b0;
      passo("expirou_pulso_unico");

      // Fill the whole lot, one car at a time
      for (int b = 0; b < 2; b++) begin
         for (int v = 0; v < 4; v++) begin
            CHEGADA = 1'b1; V_SEL = 2'(v); B_SEL = 1'(b); L_SEL = 1'b1;
            if (b == 0) e_ve[v] = 1'b1;
            else        e_vd[v] = 1'b1;
            e_can = 1'b1; e_v = 2'(v); e_b = 1'(b);
            passo("enche_abre");
            CHEGADA = 1'b0; SENSOR = 1'b1;
            e_can = 1'b0;
            passo("enche_sensor");
            SENSOR = 1'b0;
            passo("enche_fechando");
         end
      end

      // Full lot: request refused, then an exit clears LOTADO
      CHEGADA = 1'b1; L_SEL = 1'b0; V_SEL = 2'd0; B_SEL = 1'b0;
      e_lot = 1'b1;
      passo("lotado");
      CHEGADA = 1'b0;
      SAIDA = 1'b1; SAIDA_B = 1'b1; SAIDA_V = 2'd2;
      e_vd = 4'b1011; e_lot = 1'b0;
      passo("saida_d2_limpa_lotado");
      SAIDA = 1'b0;

      // CHEGADA held high: one reservation only, ends in timeout
      CHEGADA = 1'b1; V_SEL = 2'd2; B_SEL = 1'b1; L_SEL = 1'b1;
      e_vd = 4'b1111; e_can = 1'b1; e_v = 2'd2; e_b = 1'b1;
      passo("chegada_longa_abre");
      for (int i = 0; i < 7; i++) passo("chegada_longa_aberta");
      e_vd = 4'b1011; e_can = 1'b0; e_exp = 1'b1;
      passo("chegada_longa_expira");
      e_exp = 1'b0;
      for (int i = 0; i < 11; i++) passo("chegada_longa_sem_nova");
      CHEGADA = 1'b0;
      passo("chegada_solta");

      // Reserve D2, exit on E0 while open, then reset mid-ABERTA
      CHEGADA = 1'b1;
      e_vd = 4'b1111; e_can = 1'b1;
      passo("abre_d2");
      CHEGADA = 1'b0;
      SAIDA = 1'b1; SAIDA_B = 1'b0; SAIDA_V = 2'd0;
      e_ve = 4'b1110;
      passo("saida_e0_durante_aberta");
      SAIDA = 1'b0;
      rst_n = 1'b0;
      zera_esperado();
      passo("reset_em_aberta");
      rst_n = 1'b1;
      passo("apos_reset");

      $display("%0d/%0d checks passed", passou, total);
      $finish;
   end

endmodule
